dmem_responder: RTL

Byte-addressed, big-endian data memory that answers the processor's load/store requests through a valid/ready handshake with a programmable number of wait states. It replaces the zero-latency combinational data memory array with a multi-cycle memory slave, so the core can be tested against realistic memory latency. Storage is 32 bytes; each word access touches four consecutive bytes, most significant byte at the lowest address.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 106 ++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request/response channel between a requester and dmem_responder.
// Both directions use a valid/ready handshake; the response returns read data and an error flag.
interface dmem_responder_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Big-endian byte-addressed data memory; one request at a time, WAIT_CYCLES+1 edges from accept to access.
// Response is held until resp_ready, and no new request is taken meanwhile. DMEM_ALIGN_CHECK_EN rejects unaligned words.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q;
    logic              ready_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        mem_q [DEPTH];

    // Byte addresses of the word wrap modulo the memory depth.
    logic [ADDR_W-1:0] addr1_d, addr2_d, addr3_d;
    logic [31:0]       load_d;
    logic              misaligned_d;

    assign addr1_d = addr_q + ADDR_W'(1);
    assign addr2_d = addr_q + ADDR_W'(2);
    assign addr3_d = addr_q + ADDR_W'(3);
    assign load_d  = {mem_q[addr_q], mem_q[addr1_d], mem_q[addr2_d], mem_q[addr3_d]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_d = (addr_q[1:0] != 2'b00);
`else
    assign misaligned_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= RESP;
                        if (misaligned_d) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else if (write_q) begin
                            err_q            <= 1'b0;
                            rdata_q          <= wdata_q;
                            mem_q[addr_q]    <= wdata_q[31:24];
                            mem_q[addr1_d]   <= wdata_q[23:16];
                            mem_q[addr2_d]   <= wdata_q[15:8];
                            mem_q[addr3_d]   <= wdata_q[7:0];
                        end else begin
                            err_q   <= 1'b0;
                            rdata_q <= load_d;
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
